sdram_req_bridge: RTL and testbench
===================================

Name: sdram_req_bridge

Overview:
- Sits directly downstream of memory_control; replaces the behavioural SDRAM model with a real memory port.
- Converts memory_control's request strobes (read/readaddress, write/writeaddress/writedata) into Avalon-MM master transactions toward the SDRAM controller.
- Returns readdata plus a one-cycle completion pulse for each request.
- Handles waitrequest back-pressure, variable read latency, simultaneous requests and lost read responses.

Parameters:
- W, 16, data word width in bits; must be a power of two.
- ADDR_W, 25, width of the bit-granular request addresses and of the word-granular avm_address.
- TIMEOUT, 64, maximum cycles from read-command acceptance to avm_readdatavalid before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- read  in  1  read request; a request is taken on its 0->1 transition.
- readaddress  in  ADDR_W  bit address of the read word; a multiple of W.
- write  in  1  write request; a request is taken on its 0->1 transition.
- writeaddress  in  ADDR_W  bit address of the write word; a multiple of W.
- writedata  in  W  write data.
- readdata  out  W  last returned read word; held until the next read completes.
- read_ack  out  1  one-cycle pulse when readdata is updated.
- write_ack  out  1  one-cycle pulse when a write is accepted by the controller.
- busy  out  1  high while any request is pending or in flight.
- err  out  1  one-cycle pulse on read timeout.
- avm_address  out  ADDR_W  word address = request bit address >> log2(W), zero-extended.
- avm_read  out  1  Avalon read command.
- avm_write  out  1  Avalon write command.
- avm_writedata  out  W  Avalon write data.
- avm_waitrequest  in  1  controller stall.
- avm_readdata  in  W  returned read data.
- avm_readdatavalid  in  1  read data qualifier.

Behaviour:
- Reset state: all outputs 0; FSM in IDLE; pending flags cleared; timeout counter 0.
- Reset mid-transaction: abort immediately with no ack and no err. A readdatavalid arriving after reset is ignored.
- Edge detect: register read_q and write_q. rd_edge = read & ~read_q; wr_edge = write & ~write_q.
- On rd_edge, latch readaddress and set rd_pend. On wr_edge, latch writeaddress/writedata and set wr_pend.
- A new edge of an already-pending type overwrites the latch; only one request of each type is held.
- busy = rd_pend | wr_pend | (state != IDLE).
- IDLE:
  - If wr_pend (including one latched this same cycle): go to WR_CMD. Write has priority on simultaneous edges; the read stays pending.
  - Else if rd_pend: go to RD_CMD.
- Commands are issued one cycle after the edge at the earliest. An edge arriving while the FSM is in IDLE is serviced next cycle.
- WR_CMD:
  - Drive avm_write=1 with the latched word address and data.
  - Hold all command signals stable while avm_waitrequest=1.
  - On the cycle with avm_waitrequest=0: clear wr_pend; pulse write_ack the next cycle; go to IDLE.
- RD_CMD:
  - Drive avm_read=1 and hold while avm_waitrequest=1.
  - On acceptance: clear rd_pend; load the timeout counter with 0; go to RD_WAIT.
- RD_WAIT:
  - Counter increments each cycle.
  - On avm_readdatavalid=1: register avm_readdata into readdata; pulse read_ack the same edge (readdata and read_ack change together); go to IDLE.
  - If the counter reaches TIMEOUT-1 without valid: pulse err; readdata unchanged; go to IDLE.
  - avm_readdatavalid in any other state is ignored.
- Single outstanding read only; no pipelining across requests.
- Latency with waitrequest=0 and read latency R:
  - Read: edge at cycle 0, command at cycle 1, read_ack R cycles after command acceptance.
  - Write: edge at cycle 0, command at cycle 1, write_ack at cycle 2.
- Address arithmetic: low log2(W) address bits are discarded with no alignment check. The upper bits are zero-filled.

Test Plan:
- Read, no stall: readaddress=32, avm_readdata=16'h00AB returned 2 cycles after acceptance -> avm_address=2; avm_read high for exactly 1 cycle; readdata=16'h00AB with read_ack 1 pulse.
- Write with stall: writeaddress=1600, writedata=16'h0042, waitrequest held 3 cycles -> avm_write/address=100/data held stable for 4 cycles; write_ack once, 1 cycle after acceptance.
- Simultaneous edges (read addr 16, write addr 48) -> write to word 3 issued first; then read of word 1; write_ack precedes read_ack; busy stays high throughout.
- Timeout: TIMEOUT=8, readdatavalid never asserted -> err pulses 8 cycles after acceptance; readdata keeps its old value; busy drops; the next read completes normally.
- Reset during RD_WAIT, then a stray readdatavalid -> no read_ack, no err; all outputs 0; the next request behaves as from power-up.
- Level-held read for 20 cycles -> exactly one transaction; a second transaction only after read goes low and then high again.

Source files
------------

// File: rtl/sdram_req_bridge.sv
// Bridges memory_control request strobes onto an Avalon-MM master port toward an
// SDRAM controller, returning read data and one-cycle completion pulses.
module sdram_req_bridge #(
  parameter int W       = 16,
  parameter int ADDR_W  = 25,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic [ADDR_W-1:0] readaddress,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeaddress,
  input  logic [W-1:0]      writedata,
  output logic [W-1:0]      readdata,
  output logic              read_ack,
  output logic              write_ack,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [W-1:0]      avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [W-1:0]      avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int SHIFT = $clog2(W);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WR_CMD, RD_CMD, RD_WAIT} state_t;

  state_t            state, state_nx;
  logic              read_q, write_q;
  logic              rd_edge, wr_edge;
  logic              rd_pend, wr_pend;
  logic              rd_go, wr_go, accept, rd_done, rd_tmo;
  logic [ADDR_W-1:0] rd_addr, wr_addr, cmd_addr;
  logic [W-1:0]      wr_data, cmd_data;
  logic [CNT_W-1:0]  cnt;

  assign rd_edge = read & ~read_q;
  assign wr_edge = write & ~write_q;

  // A request edge seen in IDLE is launched directly from the inputs,
  // so the command appears on the very next cycle.
  always_comb begin
    state_nx = state;
    rd_go    = 1'b0;
    wr_go    = 1'b0;
    accept   = 1'b0;
    rd_done  = 1'b0;
    rd_tmo   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_pend | wr_edge) begin
          wr_go    = 1'b1;
          state_nx = WR_CMD;
        end else if (rd_pend | rd_edge) begin
          rd_go    = 1'b1;
          state_nx = RD_CMD;
        end
      end
      WR_CMD: begin
        if (!avm_waitrequest) begin
          accept   = 1'b1;
          state_nx = IDLE;
        end
      end
      RD_CMD: begin
        if (!avm_waitrequest) begin
          accept   = 1'b1;
          state_nx = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (avm_readdatavalid) begin
          rd_done  = 1'b1;
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          rd_tmo   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control: state, edge detectors, pending flags, completion pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      rd_pend   <= 1'b0;
      wr_pend   <= 1'b0;
      cnt       <= '0;
      read_ack  <= 1'b0;
      write_ack <= 1'b0;
      err       <= 1'b0;
      readdata  <= '0;
    end else begin
      state     <= state_nx;
      read_q    <= read;
      write_q   <= write;
      // A pending flag is consumed when its request is loaded into the
      // command stage; an edge arriving later re-arms it.
      rd_pend   <= (rd_pend | rd_edge) & ~rd_go;
      wr_pend   <= (wr_pend | wr_edge) & ~wr_go;
      write_ack <= (state == WR_CMD) & accept;
      read_ack  <= rd_done;
      err       <= rd_tmo;
      if (rd_done)
        readdata <= avm_readdata;
      if ((state == RD_CMD) && accept)
        cnt <= '0;
      else if (state == RD_WAIT)
        cnt <= cnt + 1'b1;
    end
  end

  // Data: request latches and the command snapshot held stable under stall
  always_ff @(posedge clk) begin
    if (rd_edge)
      rd_addr <= readaddress;
    if (wr_edge) begin
      wr_addr <= writeaddress;
      wr_data <= writedata;
    end
    if (wr_go) begin
      cmd_addr <= (wr_edge ? writeaddress : wr_addr) >> SHIFT;
      cmd_data <= wr_edge ? writedata : wr_data;
    end else if (rd_go) begin
      cmd_addr <= (rd_edge ? readaddress : rd_addr) >> SHIFT;
      cmd_data <= '0;
    end
  end

  assign avm_write     = (state == WR_CMD);
  assign avm_read      = (state == RD_CMD);
  assign avm_address   = (avm_write | avm_read) ? cmd_addr : '0;
  assign avm_writedata = avm_write ? cmd_data : '0;
  assign busy          = rd_pend | wr_pend | (state != IDLE);

endmodule

// File: tb/tb_sdram_req_bridge.sv
// Directed bench for sdram_req_bridge: a vector table for the basic read, stalled
// write and simultaneous-edge flows, plus sequences for timeout, reset and level-held requests.
module tb_sdram_req_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        read, write;
  logic [24:0] readaddress, writeaddress;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        read_ack, write_ack, busy, err;
  logic [24:0] avm_address;
  logic        avm_read, avm_write;
  logic [15:0] avm_writedata;
  logic        avm_waitrequest;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_req_bridge #(.W(16), .ADDR_W(25), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .read(read), .readaddress(readaddress),
    .write(write), .writeaddress(writeaddress), .writedata(writedata),
    .readdata(readdata), .read_ack(read_ack), .write_ack(write_ack),
    .busy(busy), .err(err),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
  );

  typedef struct {
    logic        rd;
    logic [24:0] raddr;
    logic        wr;
    logic [24:0] waddr;
    logic [15:0] wdata;
    logic        wreq;
    logic [15:0] rdata;
    logic        rvld;
    logic        e_read;
    logic        e_write;
    logic [24:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_rack;
    logic        e_wack;
    logic        e_busy;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input int rd, input int raddr, input int wr, input int waddr,
                              input int wdata, input int wreq, input int rdata, input int rvld,
                              input int e_read, input int e_write, input int e_addr,
                              input int e_wdata, input int e_rack, input int e_wack,
                              input int e_busy, input int e_rdata);
    vec_t v;
    v.rd      = 1'(rd);
    v.raddr   = 25'(raddr);
    v.wr      = 1'(wr);
    v.waddr   = 25'(waddr);
    v.wdata   = 16'(wdata);
    v.wreq    = 1'(wreq);
    v.rdata   = 16'(rdata);
    v.rvld    = 1'(rvld);
    v.e_read  = 1'(e_read);
    v.e_write = 1'(e_write);
    v.e_addr  = 25'(e_addr);
    v.e_wdata = 16'(e_wdata);
    v.e_rack  = 1'(e_rack);
    v.e_wack  = 1'(e_wack);
    v.e_busy  = 1'(e_busy);
    v.e_rdata = 16'(e_rdata);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " readdata"},      32'(readdata), 0);
    chk({tag, " read_ack"},      32'(read_ack), 0);
    chk({tag, " write_ack"},     32'(write_ack), 0);
    chk({tag, " busy"},          32'(busy), 0);
    chk({tag, " err"},           32'(err), 0);
    chk({tag, " avm_address"},   32'(avm_address), 0);
    chk({tag, " avm_read"},      32'(avm_read), 0);
    chk({tag, " avm_write"},     32'(avm_write), 0);
    chk({tag, " avm_writedata"}, 32'(avm_writedata), 0);
  endtask

  initial begin
    int n_rd;
    int n_ack;
    int n_err;
    string tag;

    //          rd raddr wr waddr  wdata   wreq rdata   rvld | rd wr addr wdata   rack wack busy rdata
    tbl[0]  = mk(1, 32,  0, 0,     0,      0,   0,      0,     1, 0, 2,   0,      0, 0, 1, 0);
    tbl[1]  = mk(1, 32,  0, 0,     0,      0,   0,      0,     0, 0, 0,   0,      0, 0, 1, 0);
    tbl[2]  = mk(1, 32,  0, 0,     0,      0,   0,      0,     0, 0, 0,   0,      0, 0, 1, 0);
    tbl[3]  = mk(1, 32,  0, 0,     0,      0,   'hAB,   1,     0, 0, 0,   0,      1, 0, 0, 'hAB);
    tbl[4]  = mk(0, 0,   0, 0,     0,      0,   0,      0,     0, 0, 0,   0,      0, 0, 0, 'hAB);
    tbl[5]  = mk(0, 0,   1, 1600,  'h42,   1,   0,      0,     0, 1, 100, 'h42,   0, 0, 1, 'hAB);
    tbl[6]  = mk(0, 0,   1, 1600,  'h42,   1,   0,      0,     0, 1, 100, 'h42,   0, 0, 1, 'hAB);
    tbl[7]  = mk(0, 0,   1, 999,   'h1234, 1,   0,      0,     0, 1, 100, 'h42,   0, 0, 1, 'hAB);
    tbl[8]  = mk(0, 0,   1, 999,   'h1234, 1,   0,      0,     0, 1, 100, 'h42,   0, 0, 1, 'hAB);
    tbl[9]  = mk(0, 0,   1, 999,   'h1234, 0,   0,      0,     0, 0, 0,   0,      0, 1, 0, 'hAB);
    tbl[10] = mk(0, 0,   0, 0,     0,      0,   0,      0,     0, 0, 0,   0,      0, 0, 0, 'hAB);
    tbl[11] = mk(1, 16,  1, 48,    'h5555, 0,   0,      0,     0, 1, 3,   'h5555, 0, 0, 1, 'hAB);
    tbl[12] = mk(1, 16,  1, 48,    'h5555, 0,   0,      0,     0, 0, 0,   0,      0, 1, 1, 'hAB);
    tbl[13] = mk(1, 16,  1, 48,    'h5555, 0,   0,      0,     1, 0, 1,   0,      0, 0, 1, 'hAB);
    tbl[14] = mk(1, 16,  1, 48,    'h5555, 0,   0,      0,     0, 0, 0,   0,      0, 0, 1, 'hAB);
    tbl[15] = mk(1, 16,  1, 48,    'h5555, 0,   'h0BEE, 1,     0, 0, 0,   0,      1, 0, 0, 'h0BEE);
    tbl[16] = mk(0, 0,   0, 0,     0,      0,   0,      0,     0, 0, 0,   0,      0, 0, 0, 'h0BEE);

    rst = 1'b1;
    read = 1'b0; write = 1'b0;
    readaddress = '0; writeaddress = '0; writedata = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 17; i++) begin
      read              = tbl[i].rd;
      readaddress       = tbl[i].raddr;
      write             = tbl[i].wr;
      writeaddress      = tbl[i].waddr;
      writedata         = tbl[i].wdata;
      avm_waitrequest   = tbl[i].wreq;
      avm_readdata      = tbl[i].rdata;
      avm_readdatavalid = tbl[i].rvld;
      tick();
      tag = $sformatf("vec%0d", i);
      chk({tag, " avm_read"},      32'(avm_read), 32'(tbl[i].e_read));
      chk({tag, " avm_write"},     32'(avm_write), 32'(tbl[i].e_write));
      chk({tag, " avm_address"},   32'(avm_address), 32'(tbl[i].e_addr));
      chk({tag, " avm_writedata"}, 32'(avm_writedata), 32'(tbl[i].e_wdata));
      chk({tag, " read_ack"},      32'(read_ack), 32'(tbl[i].e_rack));
      chk({tag, " write_ack"},     32'(write_ack), 32'(tbl[i].e_wack));
      chk({tag, " busy"},          32'(busy), 32'(tbl[i].e_busy));
      chk({tag, " err"},           32'(err), 0);
      chk({tag, " readdata"},      32'(readdata), 32'(tbl[i].e_rdata));
    end

    // Level-held read: one transaction only until read drops and rises again
    read = 1'b1; readaddress = 25'd64;
    avm_waitrequest = 1'b0; avm_readdata = 16'h7777; avm_readdatavalid = 1'b1;
    n_rd = 0; n_ack = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (avm_read) n_rd++;
      if (read_ack) n_ack++;
    end
    chk("level avm_read cycles", 32'(n_rd), 1);
    chk("level read_ack pulses", 32'(n_ack), 1);
    chk("level readdata", 32'(readdata), 32'h7777);
    read = 1'b0;
    tick();
    read = 1'b1;
    tick();
    chk("rerise avm_read", 32'(avm_read), 1);
    chk("rerise avm_address", 32'(avm_address), 4);
    tick();
    tick();
    chk("rerise read_ack", 32'(read_ack), 1);
    read = 1'b0; avm_readdatavalid = 1'b0;
    tick();

    // Timeout with no readdatavalid: err 8 cycles after acceptance
    read = 1'b1; readaddress = 25'd80;
    tick();
    chk("tmo avm_address", 32'(avm_address), 5);
    tick();
    n_err = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8 && err) n_err++;
    end
    chk("tmo early err", 32'(n_err), 0);
    chk("tmo err", 32'(err), 1);
    chk("tmo read_ack", 32'(read_ack), 0);
    chk("tmo readdata kept", 32'(readdata), 32'h7777);
    chk("tmo busy", 32'(busy), 0);
    tick();
    chk("tmo err one cycle", 32'(err), 0);
    read = 1'b0;
    tick();
    read = 1'b1; readaddress = 25'd96;
    tick();
    chk("post-tmo avm_address", 32'(avm_address), 6);
    tick();
    avm_readdata = 16'h1357; avm_readdatavalid = 1'b1;
    tick();
    chk("post-tmo read_ack", 32'(read_ack), 1);
    chk("post-tmo readdata", 32'(readdata), 32'h1357);
    read = 1'b0; avm_readdatavalid = 1'b0;
    tick();

    // Reset during RD_WAIT, then a stray readdatavalid
    read = 1'b1; readaddress = 25'd32;
    tick();
    tick();
    tick();
    chk("pre-reset busy", 32'(busy), 1);
    rst = 1'b1; read = 1'b0;
    tick();
    chk_all_zero("mid-reset");
    rst = 1'b0; avm_readdata = 16'hFFFF; avm_readdatavalid = 1'b1;
    tick();
    chk_all_zero("stray valid");
    avm_readdatavalid = 1'b0;
    n_err = 0; n_ack = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (err) n_err++;
      if (read_ack) n_ack++;
    end
    chk("post-reset err pulses", 32'(n_err), 0);
    chk("post-reset read_ack pulses", 32'(n_ack), 0);
    write = 1'b1; writeaddress = 25'd32; writedata = 16'h0009;
    tick();
    chk("post-reset avm_write", 32'(avm_write), 1);
    chk("post-reset avm_address", 32'(avm_address), 2);
    chk("post-reset avm_writedata", 32'(avm_writedata), 9);
    tick();
    chk("post-reset write_ack", 32'(write_ack), 1);
    write = 1'b0;
    tick();
    chk("final idle busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
